// File: rtl/xor_reduce_serial.sv
// xor_reduce_serial: handshaked, multi-cycle XOR parity engine.
// A WIDTH-bit word is folded BITS_PER_CYCLE bits per clock into a one-bit
// accumulator seeded with the odd/even select, then held until the consumer
// takes it. Every 2-input XOR is assembled from the 2:1 mux cell.

// 2:1 multiplexer cell: y = sel ? d1 : d0.
module mux (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);
  assign y = sel ? d1 : d0;
endmodule

// Two-input XOR from two mux cells: the first builds ~a from constants,
// the second picks a or ~a depending on b.
module xor2_mux (
  input  logic a,
  input  logic b,
  output logic y
);
  logic a_n;

  mux u_inv (.d0(1'b1), .d1(1'b0), .sel(a), .y(a_n));
  mux u_xor (.d0(a),    .d1(a_n),  .sel(b), .y(y));
endmodule

module xor_reduce_serial #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_invert,
  output logic             down_valid,
  input  logic             down_ready,
  output logic             down_parity
);

  // Number of fold cycles and the counter sized to hold it.
  localparam int S  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(S + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(S - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  shreg;
  logic [WIDTH-1:0]  shreg_shifted;
  logic              acc;
  logic [CW-1:0]     cnt;
  logic [BITS_PER_CYCLE:0] chain;
  logic              accept;
  logic              drain;
  logic              last_chunk;

  // Handshake outputs decode straight from state, so there is no
  // combinational path from up_valid or down_ready.
  assign up_ready    = (state == IDLE);
  assign down_valid  = (state == DONE);
  assign down_parity = acc;

  assign accept     = up_valid && up_ready;
  assign drain      = down_valid && down_ready;
  assign last_chunk = (cnt == LAST_CNT);

  // XOR chain: acc folded with the low BITS_PER_CYCLE bits of shreg.
  assign chain[0] = acc;
  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_fold
    xor2_mux u_xor (.a(chain[i]), .b(shreg[i]), .y(chain[i+1]));
  end

  // Zero-filled right shift by one chunk; a single-chunk word empties out.
  if (S == 1) begin : g_shift_one
    assign shreg_shifted = '0;
  end else begin : g_shift_many
    assign shreg_shifted = {{BITS_PER_CYCLE{1'b0}}, shreg[WIDTH-1:BITS_PER_CYCLE]};
  end

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode: load in IDLE, fold S chunks in BUSY, wait for drain in DONE.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)     state_nxt = BUSY;
      BUSY:    if (last_chunk) state_nxt = DONE;
      DONE:    if (drain)      state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Datapath: capture word and invert select, then shift/fold/count while busy.
  // acc is left untouched in DONE and after the drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      acc   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg <= up_data;
            acc   <= up_invert;
            cnt   <= '0;
          end
        end
        BUSY: begin
          acc   <= chain[BITS_PER_CYCLE];
          shreg <= shreg_shifted;
          cnt   <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_reduce_serial.sv
// Self-checking bench for xor_reduce_serial: reference vectors, backpressure,
// input isolation, mid-operation reset, degenerate configurations and a
// randomised regression against a behavioural parity model.
module tb_xor_reduce_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance: WIDTH=16, BITS_PER_CYCLE=4 (S=4).
  logic        up_valid = 1'b0;
  logic        up_ready;
  logic [15:0] up_data = '0;
  logic        up_invert = 1'b0;
  logic        down_valid;
  logic        down_ready = 1'b0;
  logic        down_parity;

  xor_reduce_serial #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut (
    .clk(clk), .rst(rst),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_invert(up_invert),
    .down_valid(down_valid), .down_ready(down_ready), .down_parity(down_parity)
  );

  // S=1 instance: WIDTH=16, BITS_PER_CYCLE=16.
  logic        s_valid = 1'b0;
  logic        s_up_ready;
  logic [15:0] s_data = '0;
  logic        s_inv = 1'b0;
  logic        s_down_valid;
  logic        s_ready = 1'b0;
  logic        s_parity;

  xor_reduce_serial #(.WIDTH(16), .BITS_PER_CYCLE(16)) dut_s1 (
    .clk(clk), .rst(rst),
    .up_valid(s_valid), .up_ready(s_up_ready), .up_data(s_data), .up_invert(s_inv),
    .down_valid(s_down_valid), .down_ready(s_ready), .down_parity(s_parity)
  );

  // One-bit instance: WIDTH=1, BITS_PER_CYCLE=1.
  logic w_valid = 1'b0;
  logic w_up_ready;
  logic w_data = 1'b0;
  logic w_inv = 1'b0;
  logic w_down_valid;
  logic w_ready = 1'b0;
  logic w_parity;

  xor_reduce_serial #(.WIDTH(1), .BITS_PER_CYCLE(1)) dut_w1 (
    .clk(clk), .rst(rst),
    .up_valid(w_valid), .up_ready(w_up_ready), .up_data(w_data), .up_invert(w_inv),
    .down_valid(w_down_valid), .down_ready(w_ready), .down_parity(w_parity)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word to the main instance; returns #1 after the accept edge.
  task automatic send(input logic [15:0] d, input logic inv);
    int guard = 0;
    while (!up_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("send_ready", up_ready, 1);
    up_data   = d;
    up_invert = inv;
    up_valid  = 1'b1;
    tick();
    up_valid  = 1'b0;
  endtask

  // Count edges from the accept until down_valid rises (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    while (!down_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("result_timeout", down_valid, 1);
  endtask

  task automatic drain();
    down_ready = 1'b1;
    tick();
    down_ready = 1'b0;
    check("drain_up_ready", up_ready, 1);
    check("drain_down_valid", down_valid, 0);
  endtask

  task automatic ref_vec(input string tag, input logic [15:0] d, input logic inv, input logic exp);
    int lat;
    send(d, inv);
    wait_result(lat);
    check({tag, "_latency"}, lat, 4);
    check({tag, "_parity"}, down_parity, exp);
    drain();
  endtask

  task automatic s1_run(input logic [15:0] d, input logic inv, input logic exp);
    check("s1_up_ready", s_up_ready, 1);
    s_data = d; s_inv = inv; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    check("s1_busy", s_down_valid, 0);
    tick();
    check("s1_valid", s_down_valid, 1);
    check("s1_parity", s_parity, exp);
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    check("s1_drain", s_up_ready, 1);
  endtask

  task automatic w1_run(input logic d, input logic inv, input logic exp);
    check("w1_up_ready", w_up_ready, 1);
    w_data = d; w_inv = inv; w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    check("w1_busy", w_down_valid, 0);
    tick();
    check("w1_valid", w_down_valid, 1);
    check("w1_parity", w_parity, exp);
    w_ready = 1'b1;
    tick();
    w_ready = 1'b0;
    check("w1_drain", w_up_ready, 1);
  endtask

  initial begin
    int lat;
    logic [15:0] rd;
    logic        ri;
    int          stall;
    int          n_sent;
    int          n_recv;

    // Reset values, visible while rst is held.
    #2;
    check("rst_up_ready", up_ready, 1);
    check("rst_down_valid", down_valid, 0);
    check("rst_down_parity", down_parity, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Reference vectors.
    ref_vec("v0001", 16'h0001, 1'b0, 1'b1);
    ref_vec("vffff_odd", 16'hFFFF, 1'b0, 1'b0);
    ref_vec("vffff_even", 16'hFFFF, 1'b1, 1'b1);
    ref_vec("va5a4", 16'hA5A4, 1'b0, 1'b1);

    // Backpressure: result held for 5 stalled cycles.
    send(16'h0007, 1'b0);
    wait_result(lat);
    check("bp_latency", lat, 4);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", down_valid, 1);
      check("bp_parity", down_parity, 1);
      check("bp_up_ready", up_ready, 0);
    end
    drain();

    // Input isolation: up_valid stays high with a new word during BUSY/DONE.
    send(16'h0003, 1'b0);
    up_data  = 16'hFFFE;
    up_valid = 1'b1;
    wait_result(lat);
    check("iso_latency", lat, 4);
    check("iso_parity", down_parity, 0);
    down_ready = 1'b1;
    tick();                          // edge D
    down_ready = 1'b0;
    check("iso_ready_after_d", up_ready, 1);
    tick();                          // edge D+1: second word accepted
    up_valid = 1'b0;
    check("iso_accept_d1", up_ready, 0);
    wait_result(lat);
    check("iso2_latency", lat, 4);
    check("iso2_parity", down_parity, 1);
    drain();

    // Mid-operation reset: asynchronous, outputs clear before any edge.
    send(16'h0001, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mrst_up_ready", up_ready, 1);
    check("mrst_down_valid", down_valid, 0);
    check("mrst_down_parity", down_parity, 0);
    @(negedge clk);
    rst = 1'b0;
    ref_vec("v8000", 16'h8000, 1'b0, 1'b1);

    // Degenerate configurations.
    s1_run(16'hA5A4, 1'b0, 1'b1);
    s1_run(16'hFFFF, 1'b1, 1'b1);
    s1_run(16'h0000, 1'b0, 1'b0);
    w1_run(1'b0, 1'b0, 1'b0);
    w1_run(1'b0, 1'b1, 1'b1);
    w1_run(1'b1, 1'b0, 1'b1);
    w1_run(1'b1, 1'b1, 1'b0);

    // Randomised regression with consumer stalls.
    n_sent = 0;
    n_recv = 0;
    for (int k = 0; k < 1000; k++) begin
      rd    = 16'($urandom);
      ri    = 1'($urandom_range(0, 1));
      stall = $urandom_range(0, 3);
      send(rd, ri);
      n_sent++;
      wait_result(lat);
      for (int j = 0; j < stall; j++) tick();
      check("rnd_valid", down_valid, 1);
      check("rnd_parity", down_parity, (^rd) ^ ri);
      if (down_valid) n_recv++;
      drain();
    end
    check("rnd_transfers", n_recv, n_sent);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xor_reduce_serial.md
# xor_reduce_serial

Parametrised, handshaked parity engine: accepts a WIDTH-bit word and folds it into a single XOR parity bit over WIDTH/BITS_PER_CYCLE clock cycles. It generalises the single mux-built XOR gate to an arbitrary-width, multi-cycle, odd/even-selectable reduction. It sits between a valid/ready producer and consumer, for example on a bus-protection or checksum path. Every 2-input XOR in the datapath is built from the team's 2:1 `mux` cell (d0, d1, sel, y) with constants and wires; the `^` operator is not used in the datapath.

## Interface
- `WIDTH`, default 16: input word width; must be ≥ 1.
- `BITS_PER_CYCLE`, default 4: bits folded per cycle.
  - Must divide WIDTH.
  - Defines S = WIDTH / BITS_PER_CYCLE, the number of processing cycles.
- `clk` input 1: clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `up_valid` input 1: producer presents a word.
- `up_ready` output 1: block can accept a word; high only in IDLE.
- `up_data` input WIDTH: word to reduce; sampled only at the accept edge.
- `up_invert` input 1: sampled with `up_data`.
  - 0 selects odd-parity output, i.e. the XOR of all bits.
  - 1 selects even-parity output, i.e. the inverted XOR.
- `down_valid` output 1: result available; high only in DONE.
- `down_ready` input 1: consumer takes the result.
- `down_parity` output 1: result bit; meaningful while `down_valid` is high.

## Operation
- Registers:
  - `state`: IDLE, BUSY or DONE.
  - `shreg`: WIDTH bits.
  - `acc`: 1 bit.
  - `cnt`: $clog2(S+1) bits.
- Reset (async, any state): state = IDLE, shreg = 0, acc = 0, cnt = 0. Outputs: `up_ready` = 1, `down_valid` = 0, `down_parity` = 0.
- IDLE:
  - `up_ready` = 1.
  - On up_valid && up_ready: shreg ← up_data, acc ← up_invert, cnt ← 0, go to BUSY.
  - Otherwise hold.
- BUSY:
  - `up_ready` = 0; `up_valid` and `up_data` are ignored.
  - Each edge: acc ← acc XOR shreg[0] XOR … XOR shreg[BITS_PER_CYCLE-1], as a chain of BITS_PER_CYCLE mux-XOR cells.
  - Each edge: shreg ← shreg >> BITS_PER_CYCLE (zero fill); cnt ← cnt + 1.
  - On the edge where cnt == S-1, i.e. the last chunk is folded, go to DONE.
- DONE:
  - `down_valid` = 1; `down_parity` = acc, held stable.
  - On down_valid && down_ready: go to IDLE.
  - While `down_ready` is low, stay in DONE with acc unchanged.
- Arithmetic: the final acc equals XOR-reduce(up_data) XOR up_invert. Bits are folded LSB chunk first; order does not affect the result.
- No overlap: a new word is never accepted in BUSY or DONE, including the cycle in which DONE is being drained.

## Timing
- Accept at edge E0. Chunks are folded at edges E1…ES.
  - `down_valid` rises after edge ES, giving a latency of S cycles from accept to result.
- BITS_PER_CYCLE == WIDTH (S = 1): one BUSY cycle; `down_valid` is high in the cycle after the accept edge + 1.
- Drain at edge D (down_valid && down_ready): `up_ready` is high from after edge D. The earliest next accept is edge D+1.
  - Back-to-back throughput is therefore one word per S+2 cycles.
- `up_ready` and `down_valid` are decoded directly from `state`, with no combinational path from `up_valid` or `down_ready`.
- `down_parity` is driven from the `acc` register. It is 0 in IDLE after reset; after a drain, only `down_valid` qualifies it.
- Reset asserted mid-BUSY or mid-DONE: the word in flight is discarded. Outputs take reset values immediately, without waiting for a clock edge.
  - After reset deassertion, the first accept can occur on the next edge with `up_valid` high.
- `up_valid` high while `up_ready` is low has no effect, and is not queued.

## Test plan
- Reference values for WIDTH=16, BITS_PER_CYCLE=4: 16'h0001, invert=0 → down_valid rises 4 cycles after accept, parity=1. 16'hFFFF, invert=0 → 0. 16'hFFFF, invert=1 → 1. 16'hA5A4, invert=0 → 1.
- Backpressure:
  - Stimulus: 16'h0007, invert=0, down_ready held low 5 cycles after down_valid rises.
  - Response: down_valid=1 and parity=1 stable for all 5 cycles, up_ready=0. One cycle after down_ready=1, up_ready=1.
- Input isolation:
  - Stimulus: after accepting 16'h0003, toggle up_data to 16'hFFFE with up_valid held high during BUSY and DONE.
  - Response: result parity=0; the second word is accepted only at edge D+1; its parity, 1, follows S cycles later.
- Mid-operation reset:
  - Stimulus: assert rst 2 cycles into BUSY.
  - Response: immediately up_ready=1, down_valid=0, down_parity=0. A subsequent word, 16'h8000, yields parity=1 with the normal 4-cycle latency.
- Degenerate configs:
  - Stimulus: WIDTH=16, BITS_PER_CYCLE=16 (S=1), and WIDTH=1, BITS_PER_CYCLE=1.
  - Response: result 1 cycle after accept; for WIDTH=1, parity equals up_data XOR up_invert for all four input combinations.
- Randomised regression: 1000 random words and invert values with random down_ready stalls. Every result must match XOR-reduce(data) XOR invert, and there must be no lost or duplicated transfers.
